// File: rtl/activation_packer.sv
// activation_packer: ReLU, rounded right-shift requantization and unsigned saturation of
// adder-tree outputs, packed PACK-per-word into a FIFO. Define ACT_ZERO_CNT_EN for zero_count.
module activation_packer #(
  parameter int IN_W       = 20,
  parameter int OUT_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FILL_DEPTH = 3,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      tile_len,
  input  logic [4:0]            shift_amt,
  input  logic [IN_W-1:0]       ofm_input,
  input  logic                  ready_activation,
  output logic [OUT_W*PACK-1:0] act_data,
  output logic                  act_valid,
  input  logic                  act_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
`ifdef ACT_ZERO_CNT_EN
  output logic [LEN_W-1:0]      zero_count,
`endif
  output logic [1:0]            state_dbg
);

  localparam int FILL_W = $clog2(FILL_DEPTH + 2);
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int WORD_W = OUT_W * PACK;
  localparam logic [IN_W:0] SAT_MAX = (IN_W + 1)'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state_q;
  logic [FILL_W-1:0] fill_cnt;
  logic [LEN_W-1:0]  elem_cnt;
  logic [LEN_W-1:0]  last_idx;
  logic [4:0]        shift_q;

  // Stage 1: requantized value before saturation.
  logic              s1_valid;
  logic              s1_last;
  logic [IN_W:0]     s1_y;

  // Stage 2: lane assembly and the word waiting to enter the FIFO.
  logic [LANE_W-1:0] lane_cnt;
  logic [WORD_W-1:0] pack_q;
  logic              push_q;
  logic [WORD_W-1:0] push_word;

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  logic              start_acc;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic [IN_W:0]     relu_x;
  logic [IN_W:0]     rnd_add;
  logic [IN_W:0]     y_next;
  logic [OUT_W-1:0]  sat;
  logic [WORD_W-1:0] pack_next;
  logic              lane_last;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Writer handshake: a word transfers on any edge where act_valid && act_ready; act_valid
  // means the FIFO is non-empty and act_data (head entry) holds until that transfer.
  assign pop       = !fifo_empty && act_ready;
  assign push_ok   = push_q && (!fifo_full || pop);
  assign act_valid = !fifo_empty;
  assign act_data  = fifo_mem[rd_ptr[AW-1:0]];
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  // The sum cannot wrap: a non-negative IN_W input plus at most 2^IN_W fits in IN_W+1 bits.
  always_comb begin
    relu_x  = ofm_input[IN_W-1] ? '0 : {2'b00, ofm_input[IN_W-2:0]};
    rnd_add = '0;
    if (shift_q != 5'd0) begin
      rnd_add = {{IN_W{1'b0}}, 1'b1} << (shift_q - 5'd1);
    end
    y_next = (relu_x + rnd_add) >> shift_q;
  end

  always_comb begin
    sat       = (s1_y > SAT_MAX) ? '1 : s1_y[OUT_W-1:0];
    pack_next = pack_q;
    pack_next[int'(lane_cnt) * OUT_W +: OUT_W] = sat;
    lane_last = (int'(lane_cnt) == PACK - 1) || s1_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fill_cnt <= '0;
      elem_cnt <= '0;
      last_idx <= '0;
      shift_q  <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_y     <= '0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            last_idx <= (tile_len == '0) ? '0 : tile_len - 1'b1;
            shift_q  <= shift_amt;
            fill_cnt <= '0;
            elem_cnt <= '0;
            state_q  <= (FILL_DEPTH == 0) ? S_RUN : S_FILL;
          end
        end
        S_FILL: begin
          // Leading strobes carry adder-pipeline garbage; count them and drop the data.
          if (ready_activation) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (int'(fill_cnt) == FILL_DEPTH - 1) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (ready_activation) begin
            s1_valid <= 1'b1;
            s1_y     <= y_next;
            s1_last  <= (elem_cnt == last_idx);
            elem_cnt <= elem_cnt + 1'b1;
            if (elem_cnt == last_idx) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!s1_valid && !push_q && fifo_empty) begin
            state_q <= S_IDLE;
            done    <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt  <= '0;
      pack_q    <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= 1'b0;
      if (start_acc) begin
        lane_cnt <= '0;
        pack_q   <= '0;
      end else if (s1_valid) begin
        if (lane_last) begin
          push_word <= pack_next;
          push_q    <= 1'b1;
          pack_q    <= '0;
          lane_cnt  <= '0;
        end else begin
          pack_q   <= pack_next;
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ACT_ZERO_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count <= '0;
    end else if (start_acc) begin
      zero_count <= '0;
    end else if (s1_valid && (sat == '0) && (zero_count != '1)) begin
      zero_count <= zero_count + 1'b1;
    end
  end
`endif

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        fifo_mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (start_acc) begin
        overflow_err <= 1'b0;
      end else if (push_q && !push_ok) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_activation_packer.sv
// Directed bench for activation_packer: reset, requant/packing, partial words, FIFO overflow,
// ignored start/strobes and zero-length tiles. Define ACT_ZERO_CNT_EN to cover zero_count.
module tb_activation_packer;

  localparam int IN_W   = 20;
  localparam int OUT_W  = 8;
  localparam int PACK   = 4;
  localparam int LEN_W  = 16;
  localparam int WORD_W = OUT_W * PACK;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  tile_len;
  logic [4:0]        shift_amt;
  logic [IN_W-1:0]   ofm_input;
  logic              ready_activation;
  logic [WORD_W-1:0] act_data;
  logic              act_valid;
  logic              act_ready;
  logic              busy;
  logic              done;
  logic              overflow_err;
  logic [1:0]        state_dbg;
`ifdef ACT_ZERO_CNT_EN
  logic [LEN_W-1:0]  zero_count;
`endif

  int vectors;
  int miscompares;
  int done_cnt;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] exp_w;

  activation_packer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .tile_len         (tile_len),
    .shift_amt        (shift_amt),
    .ofm_input        (ofm_input),
    .ready_activation (ready_activation),
    .act_data         (act_data),
    .act_valid        (act_valid),
    .act_ready        (act_ready),
    .busy             (busy),
    .done             (done),
    .overflow_err     (overflow_err),
`ifdef ACT_ZERO_CNT_EN
    .zero_count       (zero_count),
`endif
    .state_dbg        (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every accepted word is checked against the expected queue.
  always @(negedge clk) begin
    if (!rst && act_valid && act_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word got=%h expected=none", act_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_data !== exp_w) begin
          miscompares++;
          $display("FAIL word got=%h expected=%h", act_data, exp_w);
        end
      end
    end
    if (!rst && done) done_cnt++;
  end

  // Driver tasks: all are entered and left 1 ns after a rising edge.
  task automatic start_tile(input int len, input int sh);
    tile_len  = LEN_W'(len);
    shift_amt = 5'(sh);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic strobe(input int v);
    ofm_input        = IN_W'(v);
    ready_activation = 1'b1;
    @(posedge clk); #1;
    ready_activation = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int d0;
    if (act_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b%b%b%b expected=0000", act_valid, busy, done, overflow_err);
    end
    vectors++;
    if (act_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got=%h expected=0", act_data);
    end
    vectors++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);
    d0 = done_cnt;
    start_tile(4, 0);
    strobe(11);
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_fill got=%b expected=1", busy);
    end
    vectors++;
    ofm_input        = IN_W'(12);
    ready_activation = 1'b1;
    #2 rst = 1'b1;
    #1;
    if (act_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midtile_reset got=%b%b%b%b expected=0000", act_valid, busy, done, overflow_err);
    end
    vectors++;
    @(posedge clk); #1;
    ready_activation = 1'b0;
    rst = 1'b0;
    idle_cycles(6);
    if (done_cnt !== d0 || act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset done=%0d expected=%0d valid=%b", done_cnt, d0, act_valid);
    end
    vectors++;
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    act_ready = 1'b1;
    exp_q.push_back(32'hFFFF0005);
    start_tile(4, 0);
    strobe(999); strobe(999); strobe(999);
    strobe(5); strobe(-7); strobe(300); strobe(255);
    @(negedge clk);
    if (act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_1 got=%b expected=0", act_valid);
    end
    vectors++;
    @(negedge clk);
    if (act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_2 got=%b expected=0", act_valid);
    end
    vectors++;
    @(negedge clk);
    if (act_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_3 got=%b expected=1", act_valid);
    end
    vectors++;
    @(posedge clk); #1;
    idle_cycles(10);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done dones=%0d expected=1 pending=%0d busy=%b", done_cnt - d0, exp_q.size(), busy);
    end
    vectors++;
`ifdef ACT_ZERO_CNT_EN
    if (zero_count !== 16'd1) begin
      miscompares++;
      $display("FAIL basic_zero_count got=%0d expected=1", zero_count);
    end
    vectors++;
`endif
  endtask

  task automatic test_round;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(32'h00FF0102);
    start_tile(4, 2);
    strobe(1); strobe(2); strobe(3);
    strobe(6); strobe(5); strobe(1022); strobe(0);
    idle_cycles(12);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL round_done dones=%0d expected=1 pending=%0d", done_cnt - d0, exp_q.size());
    end
    vectors++;
`ifdef ACT_ZERO_CNT_EN
    if (zero_count !== 16'd1) begin
      miscompares++;
      $display("FAIL round_zero_count got=%0d expected=1", zero_count);
    end
    vectors++;
`endif
  endtask

  task automatic test_partial;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h00000605);
    start_tile(6, 0);
    strobe(0); strobe(0); strobe(0);
    for (int i = 1; i <= 6; i++) strobe(i);
    idle_cycles(12);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL partial_done dones=%0d expected=1 pending=%0d", done_cnt - d0, exp_q.size());
    end
    vectors++;
  endtask

  task automatic test_overflow;
    int d0;
    d0 = done_cnt;
    act_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h01010101);
    start_tile(20, 0);
    strobe(0); strobe(0); strobe(0);
    for (int i = 0; i < 20; i++) strobe(1);
    idle_cycles(6);
    if (overflow_err !== 1'b1 || act_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag got err=%b valid=%b busy=%b expected=111", overflow_err, act_valid, busy);
    end
    vectors++;
    @(negedge clk);
    if (act_data !== 32'h01010101) begin
      miscompares++;
      $display("FAIL held_data_a got=%h expected=01010101", act_data);
    end
    vectors++;
    @(negedge clk);
    if (act_data !== 32'h01010101 || done_cnt !== d0) begin
      miscompares++;
      $display("FAIL held_data_b got=%h expected=01010101 dones=%0d", act_data, done_cnt - d0);
    end
    vectors++;
    @(posedge clk); #1;
    act_ready = 1'b1;
    idle_cycles(12);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL overflow_drain dones=%0d expected=1 pending=%0d", done_cnt - d0, exp_q.size());
    end
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky got=%b expected=1", overflow_err);
    end
    vectors++;
  endtask

  task automatic test_ignore;
    int d0;
    for (int i = 0; i < 5; i++) strobe(7);
    idle_cycles(6);
    if (act_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_strobes got valid=%b busy=%b expected=00", act_valid, busy);
    end
    vectors++;
    d0 = done_cnt;
    exp_q.push_back(32'h09000200);
    start_tile(4, 0);
    if (overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear got=%b expected=0", overflow_err);
    end
    vectors++;
    strobe(50);
    start = 1'b1;
    strobe(50);
    strobe(50);
    strobe(0);
    strobe(2);
    start = 1'b0;
    strobe(0);
    strobe(9);
    start = 1'b1;
    strobe(77);
    start = 1'b0;
    strobe(78);
    idle_cycles(12);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start dones=%0d expected=1 pending=%0d busy=%b", done_cnt - d0, exp_q.size(), busy);
    end
    vectors++;
`ifdef ACT_ZERO_CNT_EN
    if (zero_count !== 16'd2) begin
      miscompares++;
      $display("FAIL ignore_zero_count got=%0d expected=2", zero_count);
    end
    vectors++;
`endif
  endtask

  task automatic test_len_zero;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(32'h00000028);
    start_tile(0, 1);
    strobe(3); strobe(3); strobe(3);
    strobe(79);
    strobe(500);
    strobe(600);
    idle_cycles(12);
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0 || act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len_zero dones=%0d expected=1 pending=%0d valid=%b", done_cnt - d0, exp_q.size(), act_valid);
    end
    vectors++;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    done_cnt         = 0;
    rst              = 1'b1;
    start            = 1'b0;
    tile_len         = '0;
    shift_amt        = '0;
    ofm_input        = '0;
    ready_activation = 1'b0;
    act_ready        = 1'b1;
    #3;
    test_reset();
    test_basic();
    test_round();
    test_partial();
    test_overflow();
    test_ignore();
    test_len_zero();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_words got=%0d expected=0", exp_q.size());
    end
    vectors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
